// File: rtl/jpeg_output_pkg.sv
// rtl/jpeg_output_pkg.sv - shared constants, bank state and pixel level-shift for the JPEG output buffer
package jpeg_output_pkg;

    localparam int BLOCK_SAMPLES = 64;
    localparam int PIX_PER_BEAT  = 4;
    localparam int BEATS         = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_e;

    // 33-bit add so extreme IDCT outputs cannot wrap before saturation
    function automatic logic [7:0] level_shift_sat(input logic signed [31:0] sample);
        logic signed [32:0] shifted;
        shifted = 33'(sample) + 33'sd128;
        if (shifted < 33'sd0) begin
            return 8'h00;
        end else if (shifted > 33'sd255) begin
            return 8'hFF;
        end else begin
            return shifted[7:0];
        end
    endfunction

endpackage

// File: rtl/jpeg_output_bank.sv
// rtl/jpeg_output_bank.sv - one 64-pixel ping-pong bank: storage, sample counter, state and block id
module jpeg_output_bank
    import jpeg_output_pkg::*;
#(
    parameter int ID_W = 32
) (
    input  logic            clk_i,
    input  logic            flush_i,
    input  logic            wr_en_i,
    input  logic [5:0]      wr_idx_i,
    input  logic [7:0]      wr_pix_i,
    input  logic [ID_W-1:0] wr_id_i,
    input  logic            drain_start_i,
    input  logic            drain_done_i,
    input  logic [3:0]      rd_beat_i,
    output logic [31:0]     rd_word_o,
    output bank_state_e     state_o,
    output logic            last_sample_o,
    output logic [ID_W-1:0] id_o
);

    logic [7:0]      mem_q [BLOCK_SAMPLES];
    bank_state_e     state_q, state_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [ID_W-1:0] id_q, id_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        if (wr_en_i) begin
            cnt_d   = cnt_q + 7'd1;
            state_d = BANK_FILLING;
            if (cnt_q == 7'd0) begin
                id_d = wr_id_i;
            end
            if (cnt_q == 7'(BLOCK_SAMPLES - 1)) begin
                state_d = BANK_FULL;
                cnt_d   = 7'd0;
            end
        end
        if (drain_start_i) begin
            state_d = BANK_DRAINING;
        end
        if (drain_done_i) begin
            state_d = BANK_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            state_q <= BANK_EMPTY;
            cnt_q   <= 7'd0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
        end
    end

    // Storage is deliberately left untouched by a flush
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_pix_i;
        end
    end

    assign rd_word_o     = {mem_q[{rd_beat_i, 2'd3}], mem_q[{rd_beat_i, 2'd2}],
                            mem_q[{rd_beat_i, 2'd1}], mem_q[{rd_beat_i, 2'd0}]};
    assign state_o       = state_q;
    assign last_sample_o = (cnt_q == 7'(BLOCK_SAMPLES - 1));
    assign id_o          = id_q;

endmodule

// File: rtl/jpeg_output_buffer.sv
// rtl/jpeg_output_buffer.sv - level-shift, ping-pong bank write and 4-pixel raster drain after the IDCT
module jpeg_output_buffer
    import jpeg_output_pkg::*;
#(
    parameter int ID_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               img_start_i,
    input  logic               inport_valid_i,
    input  logic signed [31:0] inport_data_i,
    input  logic [5:0]         inport_idx_i,
    input  logic [ID_W-1:0]    inport_id_i,
    output logic               inport_accept_o,
    output logic               outport_valid_o,
    output logic [31:0]        outport_data_o,
    output logic [3:0]         outport_idx_o,
    output logic               outport_last_o,
    output logic [ID_W-1:0]    outport_id_o,
    input  logic               outport_accept_i,
    output logic               overflow_o
);

    logic            flush;
    bank_state_e     bank_state [2];
    logic [31:0]     bank_word  [2];
    logic [ID_W-1:0] bank_id    [2];
    logic [1:0]      bank_last;
    logic [1:0]      wr_en, drain_start, drain_done;
    logic            bank_open, wr_ok;

    logic            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic            overflow_q, accept_q;
    logic            valid_q, valid_d, last_q, last_d;
    logic [31:0]     data_q, data_d;
    logic [3:0]      idx_q, idx_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            ld, ld_bank;
    logic [3:0]      ld_beat;

    assign flush     = rst_i | img_start_i;
    assign bank_open = (bank_state[wr_bank_q] == BANK_EMPTY) || (bank_state[wr_bank_q] == BANK_FILLING);
    assign wr_ok     = inport_valid_i && bank_open && !flush;
    assign wr_en     = {wr_ok && wr_bank_q, wr_ok && !wr_bank_q};
    assign wr_bank_d = wr_bank_q ^ (wr_ok && bank_last[wr_bank_q]);

    for (genvar g = 0; g < 2; g++) begin : g_bank
        jpeg_output_bank #(.ID_W(ID_W)) u_bank (
            .clk_i         (clk_i),
            .flush_i       (flush),
            .wr_en_i       (wr_en[g]),
            .wr_idx_i      (inport_idx_i),
            .wr_pix_i      (level_shift_sat(inport_data_i)),
            .wr_id_i       (inport_id_i),
            .drain_start_i (drain_start[g]),
            .drain_done_i  (drain_done[g]),
            .rd_beat_i     (ld_beat),
            .rd_word_o     (bank_word[g]),
            .state_o       (bank_state[g]),
            .last_sample_o (bank_last[g]),
            .id_o          (bank_id[g])
        );
    end

    // Output register: advance on accept, and chain straight into the other bank after beat 15
    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        idx_d       = idx_q;
        last_d      = last_q;
        id_d        = id_q;
        rd_bank_d   = rd_bank_q;
        drain_start = 2'b00;
        drain_done  = 2'b00;
        ld          = 1'b0;
        ld_bank     = rd_bank_q;
        ld_beat     = 4'd0;
        if (valid_q && outport_accept_i) begin
            if (idx_q == 4'(BEATS - 1)) begin
                drain_done[rd_bank_q] = 1'b1;
                rd_bank_d             = ~rd_bank_q;
                valid_d               = 1'b0;
                last_d                = 1'b0;
            end else begin
                ld      = 1'b1;
                ld_beat = idx_q + 4'd1;
            end
        end
        if ((!valid_q || outport_accept_i) && !ld && bank_state[rd_bank_d] == BANK_FULL) begin
            ld                     = 1'b1;
            ld_bank                = rd_bank_d;
            ld_beat                = 4'd0;
            drain_start[rd_bank_d] = 1'b1;
        end
        if (ld) begin
            valid_d = 1'b1;
            data_d  = bank_word[ld_bank];
            idx_d   = ld_beat;
            last_d  = (ld_beat == 4'(BEATS - 1));
            id_d    = bank_id[ld_bank];
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            overflow_q <= 1'b0;
            accept_q   <= 1'b1;
            valid_q    <= 1'b0;
            data_q     <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
            id_q       <= '0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            overflow_q <= overflow_q | (inport_valid_i && !bank_open);
            accept_q   <= (bank_state[wr_bank_q] == BANK_EMPTY);
            valid_q    <= valid_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            id_q       <= id_d;
        end
    end

    assign inport_accept_o = accept_q;
    assign outport_valid_o = valid_q;
    assign outport_data_o  = data_q;
    assign outport_idx_o   = idx_q;
    assign outport_last_o  = last_q;
    assign outport_id_o    = id_q;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_jpeg_output_buffer.sv
// tb/tb_jpeg_output_buffer.sv - scoreboard bench for jpeg_output_buffer
module tb_jpeg_output_buffer;

    logic               clk_i = 1'b0;
    logic               rst_i, img_start_i, inport_valid_i, outport_accept_i;
    logic signed [31:0] inport_data_i;
    logic [5:0]         inport_idx_i;
    logic [31:0]        inport_id_i;
    logic               inport_accept_o, outport_valid_o, outport_last_o, overflow_o;
    logic [31:0]        outport_data_o, outport_id_o;
    logic [3:0]         outport_idx_o;

    always #5 clk_i = ~clk_i;

    jpeg_output_buffer #(.ID_W(32)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .img_start_i      (img_start_i),
        .inport_valid_i   (inport_valid_i),
        .inport_data_i    (inport_data_i),
        .inport_idx_i     (inport_idx_i),
        .inport_id_i      (inport_id_i),
        .inport_accept_o  (inport_accept_o),
        .outport_valid_o  (outport_valid_o),
        .outport_data_o   (outport_data_o),
        .outport_idx_o    (outport_idx_o),
        .outport_last_o   (outport_last_o),
        .outport_id_o     (outport_id_o),
        .outport_accept_i (outport_accept_i),
        .overflow_o       (overflow_o)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
        logic [31:0] id;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;
    bit    stall_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_pix(input logic signed [31:0] d);
        longint v;
        v = longint'(d) + 128;
        if (v < 0) return 8'h00;
        if (v > 255) return 8'hFF;
        return v[7:0];
    endfunction

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (stall_en) outport_accept_i = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: scoreboard compare on transfer, hold check while stalled
    logic        prev_hold = 1'b0, prev_flush = 1'b0, prev_last;
    logic [31:0] prev_data, prev_id;
    logic [3:0]  prev_idx;
    always @(negedge clk_i) begin
        beat_t e;
        if (prev_hold && !prev_flush) begin
            check("hold_out", {outport_valid_o, outport_idx_o, outport_last_o, outport_data_o},
                  {1'b1, prev_idx, prev_last, prev_data});
            check("hold_id", outport_id_o, prev_id);
        end
        if (outport_valid_o && outport_accept_i) begin
            check("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("beat_data", outport_data_o, e.data);
                check("beat_idx", outport_idx_o, e.idx);
                check("beat_last", outport_last_o, e.last);
                check("beat_id", outport_id_o, e.id);
            end
        end
        prev_hold  = outport_valid_o && !outport_accept_i;
        prev_flush = rst_i | img_start_i;
        prev_data  = outport_data_o;
        prev_idx   = outport_idx_o;
        prev_last  = outport_last_o;
        prev_id    = outport_id_o;
    end

    task automatic send_block(input int kind, input logic [31:0] blk_id, input int flush_at, input bit force_send);
        logic [7:0]         pix [64];
        logic signed [31:0] d;
        int                 ix, r, waited;
        beat_t              e;
        if (!force_send) begin
            waited = 0;
            while (!inport_accept_o && waited < 300) begin
                @(posedge clk_i); #1;
                waited++;
            end
            check("accept_wait", inport_accept_o, 1);
        end
        for (int i = 0; i < 64; i++) begin
            ix = (kind == 2) ? 63 - i : i;
            case (kind)
                0: d = 0;
                1: d = (i == 0) ? -200 : (i == 1) ? 127 : (i == 2) ? 128 : (i == 3) ? -128 : 0;
                2: d = ix - 128;
                default: begin
                    r = $urandom_range(0, 9);
                    if (r == 0) d = 32'h8000_0000;
                    else if (r == 1) d = 32'h7FFF_FFFF;
                    else d = int'($urandom_range(0, 600)) - 300;
                end
            endcase
            pix[ix]        = ref_pix(d);
            inport_valid_i = 1'b1;
            inport_data_i  = d;
            inport_idx_i   = ix[5:0];
            inport_id_i    = blk_id;
            img_start_i    = (i == flush_at);
            @(posedge clk_i); #1;
            img_start_i = 1'b0;
            if (i == flush_at) break;
        end
        inport_valid_i = 1'b0;
        if (flush_at < 0 && !force_send) begin
            for (int b = 0; b < 16; b++) begin
                e.data = {pix[4*b+3], pix[4*b+2], pix[4*b+1], pix[4*b]};
                e.idx  = b[3:0];
                e.last = (b == 15);
                e.id   = blk_id;
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_valid();
        int w = 0;
        while (!outport_valid_o && w < 20) begin
            @(posedge clk_i); #1;
            w++;
        end
        check("valid_seen", outport_valid_o, 1);
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((sb.size() != 0 || outport_valid_o) && w < 3000) begin
            @(posedge clk_i); #1;
            w++;
        end
        check("drain_done", sb.size(), 0);
    endtask

    initial begin
        int cyc, xfers;
        rst_i = 1'b1; img_start_i = 1'b0; inport_valid_i = 1'b0;
        inport_data_i = '0; inport_idx_i = '0; inport_id_i = '0; outport_accept_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid", outport_valid_o, 0);
        check("rst_last", outport_last_o, 0);
        check("rst_idx", outport_idx_o, 0);
        check("rst_data", outport_data_o, 0);
        check("rst_id", outport_id_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_accept", inport_accept_o, 1);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("post_rst_accept", inport_accept_o, 1);

        // Zero block: beat 0 one edge after the write edge of sample 63
        send_block(0, 32'h1234, -1, 0);
        check("lat_pre", outport_valid_o, 0);
        @(posedge clk_i); #1;
        check("lat_beat0", outport_valid_o, 1);
        check("zero_data", outport_data_o, 32'h8080_8080);
        check("zero_id", outport_id_o, 32'h1234);
        wait_drain();

        send_block(1, 32'h2222, -1, 0);
        wait_valid();
        check("sat_beat0", outport_data_o, 32'h00FF_FF00);
        wait_drain();

        send_block(2, 32'h3333, -1, 0);
        wait_valid();
        check("rev_beat0", outport_data_o, 32'h0302_0100);
        wait_drain();

        // Two blocks buffered behind a stalled sink, third overflows
        outport_accept_i = 1'b0;
        send_block(3, 32'hA1, -1, 0);
        send_block(3, 32'hB2, -1, 0);
        repeat (2) @(posedge clk_i);
        #1;
        check("accept_low", inport_accept_o, 0);
        check("ovf_before", overflow_o, 0);
        send_block(3, 32'hC3, -1, 1);
        check("ovf_set", overflow_o, 1);
        repeat (10) @(posedge clk_i);
        #1;
        outport_accept_i = 1'b1;
        cyc = 0; xfers = 0;
        while (xfers < 32 && cyc < 80) begin
            @(negedge clk_i);
            if (outport_valid_o && outport_accept_i) xfers++;
            cyc++;
        end
        check("no_bubble_cycles", cyc, 32);
        @(posedge clk_i); #1;
        wait_drain();

        stall_en = 1'b1;
        for (int b = 0; b < 20; b++) send_block(3, 32'h4000_0000 + b, -1, 0);
        wait_drain();
        stall_en = 1'b0;
        @(posedge clk_i); #1;
        outport_accept_i = 1'b1;
        check("ovf_sticky", overflow_o, 1);

        // Flush mid-fill
        send_block(3, 32'h5555, 30, 0);
        check("flush_fill_valid", outport_valid_o, 0);
        check("flush_fill_accept", inport_accept_o, 1);
        check("flush_fill_ovf", overflow_o, 0);

        // Flush while beat 7 is presented, with a same-cycle accept
        outport_accept_i = 1'b0;
        send_block(0, 32'h6666, -1, 0);
        @(posedge clk_i); #1;
        outport_accept_i = 1'b1;
        repeat (7) @(posedge clk_i);
        #1;
        check("beat7_idx", outport_idx_o, 7);
        img_start_i = 1'b1;
        @(posedge clk_i); #1;
        img_start_i = 1'b0;
        sb.delete();
        check("flush_drain_valid", outport_valid_o, 0);
        check("flush_drain_accept", inport_accept_o, 1);

        send_block(2, 32'h7777, -1, 0);
        wait_valid();
        check("post_flush_beat0", outport_data_o, 32'h0302_0100);
        check("post_flush_id", outport_id_o, 32'h7777);
        wait_drain();
        check("sb_empty_end", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
